// File: rtl/fifo_stream_out.sv
// rtl/fifo_stream_out.sv - credit-based skid buffer turning a fixed-latency FIFO read port into a valid/ready stream
//
// Purpose:
//   Pops an upstream FIFO whose read data appears RD_LATENCY cycles after the
//   pop strobe, parks returned words in a BUF_DEPTH-entry skid buffer and
//   presents the head word as a registered valid/ready stream. Pops are only
//   issued when a buffer slot is guaranteed for the returning word, so the
//   buffer cannot overflow.
//
// Ports:
//   clk         in   clock, all state on the rising edge
//   rst         in   asynchronous active-high reset
//   fifo_empty  in   upstream FIFO empty flag
//   fifo_pop    out  pop strobe to the upstream FIFO
//   fifo_q      in   upstream read data, valid RD_LATENCY cycles after a pop
//   flush       in   synchronous discard of buffered and in-flight words
//   out_valid   out  out_data holds a valid word
//   out_ready   in   consumer accepts the word
//   out_data    out  head-of-buffer word
//   beat_count  out  transfer counter (only with FIFO_STREAM_OUT_BEATCNT_EN)
//
// Configuration:
//   FIFO_STREAM_OUT_BEATCNT_EN  adds the 32-bit beat_count output.

module fifo_stream_out #(
    parameter int WIDTH          = 8,
    parameter int RD_LATENCY     = 1,
    parameter int BUF_DEPTH      = 4,
    parameter int BUF_ADDR_WIDTH = $clog2(BUF_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    output logic             fifo_pop,
    input  logic [WIDTH-1:0] fifo_q,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef FIFO_STREAM_OUT_BEATCNT_EN
    ,
    output logic [31:0]      beat_count
`endif
);

    localparam int CW = BUF_ADDR_WIDTH + 1;

    logic [WIDTH-1:0]          mem [BUF_DEPTH];
    logic [BUF_ADDR_WIDTH-1:0] head;
    logic [BUF_ADDR_WIDTH-1:0] tail;
    logic [BUF_ADDR_WIDTH-1:0] head_next;
    logic [CW-1:0]             occ;
    logic [CW-1:0]             occ_next;
    logic [CW-1:0]             inflight;
    logic [CW-1:0]             later;
    logic [CW-1:0]             discard_cnt;
    logic                      started;
    logic                      ret;
    logic                      capture;
    logic                      xfer;

    assign xfer = out_valid && out_ready;

    // Registered occ is used for the credit check, so a slot freed by a
    // transfer only becomes a credit on the following cycle. 'started' keeps
    // the first pop off the cycle in which rst is released.
    assign fifo_pop = started && !fifo_empty && !flush &&
                      ((occ + inflight) < CW'(BUF_DEPTH));

    generate
        if (RD_LATENCY == 0) begin : g_lat0
            assign ret      = fifo_pop;
            assign inflight = '0;
            assign later    = '0;
        end else begin : g_latn
            logic [RD_LATENCY-1:0] pipe;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pipe <= '0;
                end else begin
                    pipe[0] <= fifo_pop;
                    for (int i = 1; i < RD_LATENCY; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign ret = pipe[RD_LATENCY-1];

            always_comb begin
                inflight = '0;
                for (int i = 0; i < RD_LATENCY; i++) begin
                    inflight = inflight + CW'(pipe[i]);
                end
            end

            // Pops still outstanding once this cycle's return has landed.
            assign later = inflight - CW'(ret);
        end
    endgenerate

    // Returns are in order, so the next discard_cnt returns are exactly the
    // words that were in flight when the last flush hit.
    assign capture = ret && !flush && (discard_cnt == '0);

    always_comb begin
        occ_next  = occ + CW'(capture) - CW'(xfer);
        head_next = head + BUF_ADDR_WIDTH'(xfer);
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            mem[tail] <= fifo_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ         <= '0;
            head        <= '0;
            tail        <= '0;
            discard_cnt <= '0;
            started     <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
        end else begin
            started <= 1'b1;
            if (flush) begin
                occ         <= '0;
                head        <= '0;
                tail        <= '0;
                out_valid   <= 1'b0;
                discard_cnt <= later;
            end else begin
                if (ret && (discard_cnt != '0)) begin
                    discard_cnt <= discard_cnt - CW'(1);
                end
                if (capture) begin
                    tail <= tail + BUF_ADDR_WIDTH'(1);
                end
                head      <= head_next;
                occ       <= occ_next;
                out_valid <= (occ_next != '0);
                // Head slot equal to the write slot means the buffer is
                // otherwise empty (full is impossible while capturing), so
                // the word being captured is the new head.
                if (occ_next != '0) begin
                    out_data <= (capture && (tail == head_next)) ? fifo_q : mem[head_next];
                end
            end
        end
    end

`ifdef FIFO_STREAM_OUT_BEATCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_count <= '0;
        end else if (xfer) begin
            beat_count <= beat_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_out.sv
// tb/tb_fifo_stream_out.sv - self-checking bench for fifo_stream_out against a word-list reference model

module tb_fifo_stream_out;

    localparam int W = 8;
    localparam int L = 1;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         fifo_empty = 1'b1;
    logic         fifo_pop;
    logic [W-1:0] fifo_q = '0;
    logic         flush = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
`ifdef FIFO_STREAM_OUT_BEATCNT_EN
    logic [31:0]  beat_count;
`endif

    fifo_stream_out #(.WIDTH(W), .RD_LATENCY(L), .BUF_DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .fifo_q     (fifo_q),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
`ifdef FIFO_STREAM_OUT_BEATCNT_EN
        ,
        .beat_count (beat_count)
`endif
    );

    always #5 clk = ~clk;

    // A popped word, and the first cycle it may be offered downstream.
    typedef struct {
        logic [W-1:0] word;
        int           rdy;
    } ent_t;

    ent_t         pend[$];
    logic [W-1:0] src[$];
    int           cyc;
    int           pop_ok_cyc;
    int           checks;
    int           errors;
    int           n_pops;
    int           n_xfer;
    int           first_pop;
    int           first_xfer;
    int           last_xfer;
    logic [W-1:0] first_word;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_pops     = 0;
        n_xfer     = 0;
        first_pop  = -1;
        first_xfer = -1;
        last_xfer  = -1;
        first_word = '0;
    endtask

    task automatic load(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            if (base < 0) src.push_back(W'($urandom));
            else          src.push_back(W'(base + i));
        end
        fifo_empty = (src.size() == 0);
    endtask

    // Entered and left at posedge+1; the cycle in which rst falls is cycle 0.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_fifo_pop", {31'd0, fifo_pop}, 0);
        chk("rst_out_data", {24'd0, out_data}, 0);
        pend.delete();
        flush     = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_hold_pop", {31'd0, fifo_pop}, 0);
        rst        = 1'b0;
        cyc        = 0;
        pop_ok_cyc = 1;
        fifo_q     = W'($urandom);
        fifo_empty = (src.size() == 0);
    endtask

    task automatic tick(input logic rdy, input logic fl);
        logic   pop_s;
        logic   xfer_s;
        logic   ep;
        logic   ev;
        out_ready = rdy;
        flush     = fl;
        @(negedge clk);
        ep = (cyc >= pop_ok_cyc) && (src.size() != 0) && !fl && (pend.size() < D);
        ev = (pend.size() != 0) && (pend[0].rdy <= cyc);
        chk("fifo_pop", {31'd0, fifo_pop}, {31'd0, ep});
        chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
        if (ev) chk("out_data", {24'd0, out_data}, {24'd0, pend[0].word});
        pop_s  = fifo_pop;
        xfer_s = out_valid && out_ready;
        @(posedge clk);
        #1;
        if (xfer_s && pend.size() != 0) begin
            if (first_xfer < 0) begin
                first_xfer = cyc;
                first_word = pend[0].word;
            end
            last_xfer = cyc;
            n_xfer++;
            void'(pend.pop_front());
        end
        if (fl) pend.delete();
        if (pop_s && src.size() != 0) begin
            ent_t e;
            e.word = src.pop_front();
            e.rdy  = cyc + L + 1;
            fifo_q = e.word;
            pend.push_back(e);
            n_pops++;
            if (first_pop < 0) first_pop = cyc;
        end else begin
            fifo_q = W'($urandom);
        end
        cyc++;
        fifo_empty = (src.size() == 0);
    endtask

    initial begin
        int rem;
        checks = 0;
        errors = 0;
        cyc    = 0;
        pop_ok_cyc = 1;
        clr();
        @(posedge clk);
        #1;

        // Three words drained with out_ready held high.
        src.push_back(8'h11);
        src.push_back(8'h22);
        src.push_back(8'h33);
        do_reset();
        clr();
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
        chk("first_pop_cycle", first_pop, 1);
        chk("first_xfer_cycle", first_xfer, 3);
        chk("last_xfer_cycle", last_xfer, 5);
        chk("three_words", n_xfer, 3);

        // Stalled consumer: only BUF_DEPTH pops, then a gapless drain.
        load(100, -1);
        clr();
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0);
        chk("pops_while_stalled", n_pops, 4);
        for (int i = 0; i < 115; i++) tick(1'b1, 1'b0);
        chk("drain_count", n_xfer, 100);
        chk("drain_gapless", last_xfer - first_xfer, 99);

        // Alternating out_ready.
        load(40, -1);
        clr();
        for (int i = 0; i < 100; i++) tick(i % 2 == 0, 1'b0);
        chk("toggle_count", n_xfer, 40);

        // Flush with three words buffered and one in flight.
        src.delete();
        load(20, 8'h40);
        do_reset();
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        clr();
        for (int i = 0; i < 40; i++) tick(1'b1, 1'b0);
        chk("post_flush_first_word", {24'd0, first_word}, 32'h44);
        chk("post_flush_count", n_xfer, 16);

        // One-cycle reset pulse mid-stream.
        load(30, -1);
        do_reset();
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
        rem = src.size();
        do_reset();
        clr();
        for (int i = 0; i < 60; i++) tick(1'b1, 1'b0);
        chk("post_reset_count", n_xfer, rem);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 600; i++) begin
            if (src.size() < 3 && ($urandom % 3) == 0) load(int'($urandom_range(1, 8)), -1);
            tick(($urandom % 4) != 0, ($urandom % 40) == 0);
        end

`ifdef FIFO_STREAM_OUT_BEATCNT_EN
        src.delete();
        load(10, 8'h80);
        do_reset();
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);
        chk("beat_count", beat_count, 10);
        tick(1'b1, 1'b1);
        chk("beat_count_flush", beat_count, 10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_stream_out.md
FIFO_STREAM_OUT -- requirements
Module: fifo_stream_out

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter RD_LATENCY, default 1, cycles from fifo_pop to word on fifo_q; legal values 0, 1, 2.
REQ-003 SHALL have parameter BUF_DEPTH, default 4, skid-buffer entries; power of two, at least RD_LATENCY+2.
REQ-004 SHALL have parameter BUF_ADDR_WIDTH, default log2(BUF_DEPTH-1), computed with the team's log2 include.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 fifo_empty  input  1  upstream FIFO empty flag.
REQ-008 fifo_pop  output  1  pop strobe to upstream FIFO.
REQ-009 fifo_q  input  WIDTH  upstream read data.
REQ-010 flush  input  1  synchronous discard of buffered and in-flight words.
REQ-011 out_valid  output  1  out_data holds a valid word.
REQ-012 out_ready  input  1  consumer accepts the word.
REQ-013 out_data  output  WIDTH  head-of-buffer word.

Function
REQ-014 SHALL assert fifo_pop in a cycle iff !fifo_empty && !flush && (occ + inflight) < BUF_DEPTH; occ = buffered words, inflight = pops not yet returned.
REQ-015 SHALL capture fifo_q into the buffer tail at the end of the cycle exactly RD_LATENCY cycles after each pop, using a RD_LATENCY-deep valid shift register; RD_LATENCY=0 captures in the pop cycle.
REQ-016 SHALL register out_valid = (occ != 0) and out_data = buffer head; pop-to-out_valid latency = RD_LATENCY+1 cycles.
REQ-017 A transfer SHALL occur when out_valid && out_ready; the head pointer then advances by 1.
REQ-018 Simultaneous capture and transfer SHALL leave occ unchanged; occ width BUF_ADDR_WIDTH+1, pointers wrap modulo BUF_DEPTH.
REQ-019 Credits SHALL not be returned in the transfer cycle; with out_ready held high, steady-state throughput SHALL be 1 word/cycle when BUF_DEPTH >= RD_LATENCY+2.
REQ-020 out_data and out_valid SHALL remain stable while out_valid && !out_ready.
REQ-021 flush SHALL zero occ and pointers at the next edge; pops still in flight SHALL be tracked and their returned words discarded, never written to the buffer.
REQ-022 Transfers in the flush cycle SHALL complete normally; out_valid SHALL be 0 the cycle after flush.
REQ-023 Buffer overflow SHALL be impossible by construction; no word SHALL be duplicated or reordered.

Reset
REQ-024 On rst high, asynchronously: occ, pointers, inflight, discard count and latency pipeline = 0; out_valid = 0; fifo_pop = 0.
REQ-025 out_data SHALL be 0 after reset; buffer storage need not be reset.
REQ-026 Reset with pops in flight SHALL discard them; the first post-reset pop SHALL occur no earlier than the first edge after rst deasserts.

Configuration
REQ-027 Macro FIFO_STREAM_OUT_BEATCNT_EN, when defined, SHALL add output beat_count, 32 bits, reset 0, +1 per transfer, wrapping at 2^32, unaffected by flush.
REQ-028 Without FIFO_STREAM_OUT_BEATCNT_EN, the beat_count port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-029 Reset, FIFO holding 0x11,0x22,0x33, out_ready=1, RD_LATENCY=1 -> first pop on cycle 1 after reset; out_data 0x11,0x22,0x33 on consecutive cycles from cycle 3; out_valid then 0.
REQ-030 100 words queued, out_ready=0 -> exactly 4 pops, out_valid=1, out_data fixed at word 0; on out_ready=1 all 100 words in order with no gaps.
REQ-031 Streaming with out_ready toggled 1,0,1,0 -> no loss or duplication; out_data constant on each not-ready cycle.
REQ-032 Flush while occ=3 and inflight=1 -> next cycle out_valid=0; late returned word not output; next output is the following FIFO word.
REQ-033 rst pulsed mid-stream for 1 cycle -> out_valid and fifo_pop 0 immediately; normal draining resumes afterwards.
REQ-034 With FIFO_STREAM_OUT_BEATCNT_EN defined, 10 transfers -> beat_count = 10; unchanged across a flush.
